jk_flip_flop: RTL and testbench

//   Positive-edge-triggered JK flip-flop with synchronous active-high reset.

---
 rtl/jk_flip_flop.sv | 57 +++++
 tb/tb_jk_flip_flop.sv | 114 +++++++++++
 2 files changed

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flop lanes sharing one clock and a synchronous
// active-high reset; Qbar is the complement of the Q register.

module jk_lane #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  // Initialiser gives a known power-up state even if rst never asserts
  logic q_q = RESET_BIT;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_BIT;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jk_lane #(.RESET_BIT(RESET_VALUE[i])) u_lane (
      .clk (clk),
      .rst (rst),
      .j   (J[i]),
      .k   (K[i]),
      .q   (Q[i])
    );
  end

  assign Qbar = ~Q;
endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench: a 1-lane and a 4-lane (non-zero reset value) instance
// driven on falling edges and sampled on falling edges.

module tb_jk_flip_flop;
  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       j1, k1;
  logic       q1, qb1;
  logic [3:0] j4, k4, q4, qb4;
  int         checks = 0;
  int         failures = 0;
  bit         done = 1'b0;

  always #5 clk = ~clk;

  jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .J(j1), .K(k1), .Q(q1), .Qbar(qb1)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0101)) dut4 (
    .clk(clk), .rst(rst4), .J(j4), .K(k4), .Q(q4), .Qbar(qb4)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Complement must hold on every sampled cycle in both instances
  always @(negedge clk) begin
    if (!done) begin
      chk("qbar1_inv", {3'b0, qb1}, {3'b0, ~q1});
      chk("qbar4_inv", qb4, ~q4);
    end
  end

  initial begin
    rst1 = 1'b0; rst4 = 1'b0;
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0; k4 = 4'b0;
    #1;
    chk("pwrup_q1",  {3'b0, q1},  4'b0000);
    chk("pwrup_qb1", {3'b0, qb1}, 4'b0001);
    chk("pwrup_q4",  q4,          4'b0101);

    @(negedge clk); // t=10, after edge 5
    chk("hold_q1",  {3'b0, q1},  4'b0000);
    chk("hold_qb1", {3'b0, qb1}, 4'b0001);
    j1 = 1'b1; k1 = 1'b0;
    @(negedge clk);
    chk("set_q1", {3'b0, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b1;
    @(negedge clk);
    chk("reset_q1", {3'b0, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b1;
    @(negedge clk);
    chk("tog1_q1", {3'b0, q1}, 4'b0001);
    @(negedge clk);
    chk("tog2_q1", {3'b0, q1}, 4'b0000);
    j1 = 1'b0; k1 = 1'b0;
    @(negedge clk);
    chk("hold0_q1", {3'b0, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b0;
    @(negedge clk);
    chk("set2_q1", {3'b0, q1}, 4'b0001);
    rst1 = 1'b1;
    @(negedge clk);
    chk("rst_prio_q1", {3'b0, q1}, 4'b0000);
    rst1 = 1'b0;
    @(negedge clk);
    chk("set3_q1", {3'b0, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b0;
    #1 rst1 = 1'b1;
    #2 rst1 = 1'b0;
    @(negedge clk);
    chk("rst_glitch_q1", {3'b0, q1}, 4'b0001);
    #2 j1 = 1'b1;
    #2 j1 = 1'b0;
    #2 k1 = 1'b1;
    #2 k1 = 1'b0;
    @(negedge clk);
    chk("mid_edge_q1", {3'b0, q1}, 4'b0001);
    j1 = 1'b1; k1 = 1'b1;
    @(negedge clk);
    chk("tog3_q1", {3'b0, q1}, 4'b0000);
    j1 = 1'b0; k1 = 1'b0;

    // 4-lane instance has held its power-up value so far
    chk("hold_q4", q4, 4'b0101);
    j4 = 4'b0011; k4 = 4'b1100;
    @(negedge clk);
    chk("load_q4", q4, 4'b0011);
    j4 = 4'b1010; k4 = 4'b0110;
    @(negedge clk);
    chk("mix_q4",  q4,  4'b1001);
    chk("mix_qb4", qb4, 4'b0110);
    j4 = 4'b1111; k4 = 4'b1111;
    @(negedge clk);
    chk("tog_q4", q4, 4'b0110);
    rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b0000;
    @(negedge clk);
    chk("rst_q4", q4, 4'b0101);
    rst4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    @(negedge clk);
    chk("hold2_q4", q4, 4'b0101);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
